// File: rtl/pic_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register offsets,
// controller states and ISR field positions.
package pic_ctrl_pkg;

   localparam logic [1:0] PIC_MASK = 2'd0;
   localparam logic [1:0] PIC_MODE = 2'd1;
   localparam logic [1:0] PIC_PEND = 2'd2;
   localparam logic [1:0] PIC_ISR  = 2'd3;

   localparam int unsigned ISR_INSVC_BIT = 31;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_SVC  = 2'd2
   } pic_state_e;

endpackage

// File: rtl/pic_prio_enc.sv
// Fixed-priority encoder: bit 0 is the highest priority.
module pic_prio_enc #(
   parameter int unsigned N_SRC = 6,
   parameter int unsigned ID_W  = 3
) (
   input  logic [N_SRC-1:0] elig_i,
   output logic             any_o,
   output logic [ID_W-1:0]  id_o
);

   logic found;

   // Pick the lowest set index of the eligible vector.
   always_comb begin
      any_o = |elig_i;
      id_o  = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < N_SRC; i++) begin
         if (!found && elig_i[i]) begin
            id_o  = ID_W'(i);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/pic_ctrl.sv
// Programmable interrupt controller: per-source edge/level capture, mask,
// fixed-priority selection and a request/ack/EOI handshake towards CP0.
module pic_ctrl
   import pic_ctrl_pkg::*;
#(
   parameter int unsigned N_SRC = 6,
   parameter int unsigned ID_W  = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_SRC-1:0] src_irq,
   input  logic             bus_sel,
   input  logic             bus_we,
   input  logic [1:0]       bus_addr,
   input  logic [31:0]      bus_wdata,
   output logic [31:0]      bus_rdata,
   output logic             cpu_irq,
   input  logic             cpu_ack,
   output logic [ID_W-1:0]  cpu_vec
);

   logic [N_SRC-1:0] mask_q, mask_d;
   logic [N_SRC-1:0] mode_q, mode_d;
   logic [N_SRC-1:0] pend_q, pend_d;
   logic [N_SRC-1:0] prev_q;
   pic_state_e       state_q;
   logic             irq_q;
   logic [ID_W-1:0]  vec_q;

   logic             wr, wr_mask, wr_mode, wr_pend, eoi, ack_take;
   logic [N_SRC-1:0] elig;
   logic [N_SRC-1:0] clr;
   logic             sel_any;
   logic [ID_W-1:0]  sel_id;
   logic             unused_wdata;

   assign unused_wdata = ^bus_wdata[31:N_SRC];

   assign elig    = pend_q & mask_q;
   assign cpu_irq = irq_q;
   assign cpu_vec = vec_q;

   pic_prio_enc #(
      .N_SRC (N_SRC),
      .ID_W  (ID_W)
   ) u_prio (
      .elig_i (elig),
      .any_o  (sel_any),
      .id_o   (sel_id)
   );

   // Bus write decode and next values of the configuration registers.
   always_comb begin
      wr       = bus_sel & bus_we;
      wr_mask  = wr && (bus_addr == PIC_MASK);
      wr_mode  = wr && (bus_addr == PIC_MODE);
      wr_pend  = wr && (bus_addr == PIC_PEND);
      eoi      = wr && (bus_addr == PIC_ISR) && (state_q == ST_SVC);
      ack_take = (state_q == ST_REQ) && cpu_ack;
      mask_d   = wr_mask ? bus_wdata[N_SRC-1:0] : mask_q;
      mode_d   = wr_mode ? bus_wdata[N_SRC-1:0] : mode_q;
   end

   // Pending capture; the incoming MODE decides the source type so a
   // level->edge switch disarms immediately and edge->level starts tracking.
   always_comb begin
      pend_d = '0;
      clr    = '0;
      for (int unsigned i = 0; i < N_SRC; i++) begin
         clr[i] = (wr_pend && bus_wdata[i]) || (ack_take && (vec_q == ID_W'(i)));
         if (!mode_d[i]) begin
            pend_d[i] = src_irq[i];
         end else if (!mode_q[i]) begin
            pend_d[i] = 1'b0;
         end else begin
            pend_d[i] = (src_irq[i] & ~prev_q[i]) | (pend_q[i] & ~clr[i]);
         end
      end
   end

   // Configuration, pending and previous-sample registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         mask_q <= '0;
         mode_q <= '0;
         pend_q <= '0;
         prev_q <= '0;
      end else begin
         mask_q <= mask_d;
         mode_q <= mode_d;
         pend_q <= pend_d;
         prev_q <= src_irq;
      end
   end

   // Request/ack/EOI handshake with registered irq and vector outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         irq_q   <= 1'b0;
         vec_q   <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (sel_any) begin
                  state_q <= ST_REQ;
                  irq_q   <= 1'b1;
                  vec_q   <= sel_id;
               end
            end
            ST_REQ: begin
               if (cpu_ack) begin
                  state_q <= ST_SVC;
                  irq_q   <= 1'b0;
               end else if (sel_any) begin
                  vec_q   <= sel_id;
               end else begin
                  state_q <= ST_IDLE;
                  irq_q   <= 1'b0;
               end
            end
            ST_SVC: begin
               irq_q <= 1'b0;
               if (eoi) begin
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               irq_q   <= 1'b0;
            end
         endcase
      end
   end

   // Register read mux, zero-extended.
   always_comb begin
      bus_rdata = '0;
      case (bus_addr)
         PIC_MASK: bus_rdata[N_SRC-1:0] = mask_q;
         PIC_MODE: bus_rdata[N_SRC-1:0] = mode_q;
         PIC_PEND: bus_rdata[N_SRC-1:0] = pend_q;
         PIC_ISR: begin
            bus_rdata[ISR_INSVC_BIT] = (state_q == ST_SVC);
            bus_rdata[ID_W-1:0]      = vec_q;
         end
         default: bus_rdata = '0;
      endcase
   end

endmodule

// File: tb/tb_pic_ctrl.sv
// Directed bench for pic_ctrl: reset, edge capture, priority, level
// re-request, drop/ack race and reset during service.
module tb_pic_ctrl;
   import pic_ctrl_pkg::*;

   logic        clk;
   logic        reset;
   logic [5:0]  src_irq;
   logic        bus_sel, bus_we;
   logic [1:0]  bus_addr;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;
   logic        cpu_irq;
   logic        cpu_ack;
   logic [2:0]  cpu_vec;

   int total = 0;
   int bad   = 0;

   pic_ctrl #(.N_SRC(6), .ID_W(3)) dut (
      .clk       (clk),
      .reset     (reset),
      .src_irq   (src_irq),
      .bus_sel   (bus_sel),
      .bus_we    (bus_we),
      .bus_addr  (bus_addr),
      .bus_wdata (bus_wdata),
      .bus_rdata (bus_rdata),
      .cpu_irq   (cpu_irq),
      .cpu_ack   (cpu_ack),
      .cpu_vec   (cpu_vec)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
      bus_sel = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wdata = d;
      tick();
      bus_sel = 1'b0; bus_we = 1'b0; bus_wdata = '0;
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] d);
      bus_addr = a;
      #1;
      d = bus_rdata;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      for (int unsigned a = 0; a < 4; a++) begin
         rd(a[1:0], d);
         total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_reg%0d got=%h want=%h", a, d, 32'h0); end
      end
      total++; if (cpu_irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b want=0", cpu_irq); end
      src_irq = 6'h3F;
      tick(); tick(); tick();
      total++; if (cpu_irq !== 1'b0) begin bad++; $display("FAIL reset_masked_irq got=%b want=0", cpu_irq); end
      src_irq = 6'h00;
      tick(); tick();
   endtask

   task automatic test_edge();
      logic [31:0] d;
      bus_wr(PIC_MASK, 32'h1);
      bus_wr(PIC_MODE, 32'h1);
      src_irq = 6'h01; tick(); src_irq = 6'h00;
      rd(PIC_PEND, d);
      total++; if (d !== 32'h1) begin bad++; $display("FAIL edge_pend got=%h want=%h", d, 32'h1); end
      total++; if (cpu_irq !== 1'b0) begin bad++; $display("FAIL edge_irq_lag got=%b want=0", cpu_irq); end
      tick();
      total++; if (cpu_irq !== 1'b1) begin bad++; $display("FAIL edge_irq got=%b want=1", cpu_irq); end
      total++; if (cpu_vec !== 3'd0) begin bad++; $display("FAIL edge_vec got=%0d want=0", cpu_vec); end
      cpu_ack = 1'b1; tick(); cpu_ack = 1'b0;
      total++; if (cpu_irq !== 1'b0) begin bad++; $display("FAIL edge_ack_irq got=%b want=0", cpu_irq); end
      rd(PIC_PEND, d);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL edge_ack_pend got=%h want=%h", d, 32'h0); end
      rd(PIC_ISR, d);
      total++; if (d !== 32'h8000_0000) begin bad++; $display("FAIL edge_isr got=%h want=%h", d, 32'h8000_0000); end
      bus_wr(PIC_ISR, 32'h0);
      rd(PIC_ISR, d);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL edge_eoi_isr got=%h want=%h", d, 32'h0); end
   endtask

   task automatic test_priority();
      logic [31:0] d;
      bus_wr(PIC_MODE, 32'h3F);
      bus_wr(PIC_MASK, 32'h3F);
      src_irq = 6'h10; tick();
      src_irq = 6'h02; tick();
      total++; if (cpu_irq !== 1'b1 || cpu_vec !== 3'd4) begin bad++; $display("FAIL prio_first got=irq%b/vec%0d want=irq1/vec4", cpu_irq, cpu_vec); end
      src_irq = 6'h00; tick();
      total++; if (cpu_irq !== 1'b1 || cpu_vec !== 3'd1) begin bad++; $display("FAIL prio_preempt got=irq%b/vec%0d want=irq1/vec1", cpu_irq, cpu_vec); end
      cpu_ack = 1'b1; tick(); cpu_ack = 1'b0;
      rd(PIC_ISR, d);
      total++; if (d !== 32'h8000_0001) begin bad++; $display("FAIL prio_isr got=%h want=%h", d, 32'h8000_0001); end
      rd(PIC_PEND, d);
      total++; if (d !== 32'h10) begin bad++; $display("FAIL prio_pend got=%h want=%h", d, 32'h10); end
      bus_wr(PIC_ISR, 32'h0);
      total++; if (cpu_irq !== 1'b0) begin bad++; $display("FAIL prio_idle_gap got=%b want=0", cpu_irq); end
      tick();
      total++; if (cpu_irq !== 1'b1 || cpu_vec !== 3'd4) begin bad++; $display("FAIL prio_rereq got=irq%b/vec%0d want=irq1/vec4", cpu_irq, cpu_vec); end
      cpu_ack = 1'b1; tick(); cpu_ack = 1'b0;
      bus_wr(PIC_ISR, 32'h0);
   endtask

   task automatic test_level();
      logic [31:0] d;
      bus_wr(PIC_MODE, 32'h0);
      bus_wr(PIC_MASK, 32'h4);
      src_irq = 6'h04; tick(); tick();
      total++; if (cpu_irq !== 1'b1 || cpu_vec !== 3'd2) begin bad++; $display("FAIL level_req got=irq%b/vec%0d want=irq1/vec2", cpu_irq, cpu_vec); end
      cpu_ack = 1'b1; tick(); cpu_ack = 1'b0;
      rd(PIC_ISR, d);
      total++; if (d !== 32'h8000_0002) begin bad++; $display("FAIL level_isr got=%h want=%h", d, 32'h8000_0002); end
      rd(PIC_PEND, d);
      total++; if (d !== 32'h4) begin bad++; $display("FAIL level_pend_ack got=%h want=%h", d, 32'h4); end
      bus_wr(PIC_PEND, 32'h4);
      rd(PIC_PEND, d);
      total++; if (d !== 32'h4) begin bad++; $display("FAIL level_w1c got=%h want=%h", d, 32'h4); end
      bus_wr(PIC_ISR, 32'h0);
      total++; if (cpu_irq !== 1'b0) begin bad++; $display("FAIL level_idle_gap got=%b want=0", cpu_irq); end
      tick();
      total++; if (cpu_irq !== 1'b1) begin bad++; $display("FAIL level_rereq got=%b want=1", cpu_irq); end
      src_irq = 6'h00; tick(); tick();
      total++; if (cpu_irq !== 1'b0) begin bad++; $display("FAIL level_quiet got=%b want=0", cpu_irq); end
   endtask

   task automatic test_drop();
      logic [31:0] d;
      bus_wr(PIC_MODE, 32'h3F);
      bus_wr(PIC_MASK, 32'h1);
      src_irq = 6'h01; tick(); src_irq = 6'h00; tick();
      total++; if (cpu_irq !== 1'b1 || cpu_vec !== 3'd0) begin bad++; $display("FAIL drop_req got=irq%b/vec%0d want=irq1/vec0", cpu_irq, cpu_vec); end
      bus_wr(PIC_MASK, 32'h0);
      total++; if (cpu_irq !== 1'b1) begin bad++; $display("FAIL drop_mask_lag got=%b want=1", cpu_irq); end
      tick();
      total++; if (cpu_irq !== 1'b0) begin bad++; $display("FAIL drop_idle got=%b want=0", cpu_irq); end
      rd(PIC_PEND, d);
      total++; if (d !== 32'h1) begin bad++; $display("FAIL drop_pend_kept got=%h want=%h", d, 32'h1); end
      bus_wr(PIC_MASK, 32'h1);
      tick();
      total++; if (cpu_irq !== 1'b1) begin bad++; $display("FAIL race_req got=%b want=1", cpu_irq); end
      cpu_ack = 1'b1;
      bus_wr(PIC_MASK, 32'h0);
      cpu_ack = 1'b0;
      rd(PIC_ISR, d);
      total++; if (d !== 32'h8000_0000) begin bad++; $display("FAIL race_svc got=%h want=%h", d, 32'h8000_0000); end
      rd(PIC_PEND, d);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL race_pend got=%h want=%h", d, 32'h0); end
      bus_wr(PIC_ISR, 32'h0);
      cpu_ack = 1'b1; tick(); cpu_ack = 1'b0;
      rd(PIC_ISR, d);
      total++; if (d !== 32'h0 || cpu_irq !== 1'b0) begin bad++; $display("FAIL idle_ack got=%h/irq%b want=%h/irq0", d, cpu_irq, 32'h0); end
      bus_wr(PIC_ISR, 32'h0);
      rd(PIC_ISR, d);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL idle_eoi got=%h want=%h", d, 32'h0); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] d;
      bus_wr(PIC_MASK, 32'h1);
      src_irq = 6'h01; tick(); src_irq = 6'h00; tick();
      cpu_ack = 1'b1; tick(); cpu_ack = 1'b0;
      src_irq = 6'h01; tick(); src_irq = 6'h00;
      rd(PIC_ISR, d);
      total++; if (d !== 32'h8000_0000) begin bad++; $display("FAIL rst_mid_svc got=%h want=%h", d, 32'h8000_0000); end
      rd(PIC_PEND, d);
      total++; if (d !== 32'h1) begin bad++; $display("FAIL rst_mid_pend_pre got=%h want=%h", d, 32'h1); end
      reset = 1'b1; tick(); reset = 1'b0;
      for (int unsigned a = 0; a < 4; a++) begin
         rd(a[1:0], d);
         total++; if (d !== 32'h0) begin bad++; $display("FAIL rst_mid_reg%0d got=%h want=%h", a, d, 32'h0); end
      end
      tick();
      total++; if (cpu_irq !== 1'b0) begin bad++; $display("FAIL rst_mid_irq got=%b want=0", cpu_irq); end
   endtask

   initial begin
      reset = 1'b1; src_irq = '0; bus_sel = 1'b0; bus_we = 1'b0;
      bus_addr = '0; bus_wdata = '0; cpu_ack = 1'b0;
      test_reset();
      test_edge();
      test_priority();
      test_level();
      test_drop();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
